hough_r_accumulator: RTL and testbench
======================================

# hough_r_accumulator

Vote accumulator for the legendre segment finder: consumes the per-hit `r_bin` / `r_bin_vld` stream produced by the r-bin computation stage for one theta slice. It builds a saturating histogram of RBINS bins, scans it after the last hit, and reports the peak bin and its vote count to the segment-fit stage. Each histogram covers one segment candidate (one ROI / theta slice) and is bracketed by `start` and `hits_done` pulses.

## Interface
- W_bin_number_a, 7, width of `r_bin` and `peak_bin`
- RBINS, 128, number of histogram bins (must be ≤ 2^W_bin_number_a)
- W_CNT, 5, width of each bin counter and of `peak_count`
- MIN_HITS, 3, minimum vote count for `peak_found`

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  pulse: clear histogram, begin new candidate
- r_bin  in  W_bin_number_a  bin index of current vote
- r_bin_vld  in  1  `r_bin` valid this cycle
- hits_done  in  1  pulse: last vote of candidate has been presented (same cycle or earlier)
- busy  out  1  block is in ACCUM, SCAN or REPORT
- hit_dropped  out  1  pulse: a `r_bin_vld` was not counted
- peak_vld  out  1  one-cycle pulse: result valid
- peak_bin  out  W_bin_number_a  index of highest bin
- peak_count  out  W_CNT  vote count of `peak_bin`
- peak_found  out  1  `peak_count` ≥ MIN_HITS; qualified by `peak_vld`

## Operation
- States: IDLE, ACCUM, SCAN, REPORT.
- Reset (async, `rst_n`=0): state IDLE, all bin counters 0, scan index 0, best registers 0; `busy`, `hit_dropped`, `peak_vld`, `peak_bin`, `peak_count`, `peak_found` all 0.
- `start` in any state: all counters cleared at that edge, best registers cleared, state → ACCUM. Aborts an in-progress ACCUM/SCAN; no `peak_vld` for the aborted candidate.
- ACCUM: for each `r_bin_vld`, `count[r_bin]` increments by 1 and saturates at 2^W_CNT−1. `r_bin` ≥ RBINS is not counted, and `hit_dropped` is pulsed.
- `hits_done` in ACCUM: a vote in the same cycle is counted; state → SCAN, scan index 0. `hits_done` outside ACCUM is ignored.
- SCAN: one bin per cycle, index 0 to RBINS−1. If `count[idx]` > best_cnt (strict), then best_cnt/best_bin update. Ties therefore keep the lowest index. After idx RBINS−1, state → REPORT.
- REPORT (1 cycle): `peak_vld`=1, `peak_bin`=best_bin, `peak_count`=best_cnt, `peak_found`=(best_cnt ≥ MIN_HITS). Next state is IDLE, unless `start` is asserted (then ACCUM).
- `peak_bin`, `peak_count` and `peak_found` hold their values until the next `start` or reset.
- Empty candidate (no votes): `peak_bin`=0, `peak_count`=0, `peak_found`=0.
- `r_bin_vld` in IDLE, SCAN or REPORT, or in the same cycle as `start`: vote discarded and `hit_dropped` pulsed.
- `start` and `hits_done` in the same cycle: `start` wins; `hits_done` is ignored.

## Timing
- All outputs registered.
- `start` sampled at cycle T: `busy`=1 from T+1. Votes are accepted from T+1.
- Vote sampled at cycle t: counter update is visible at t+1, so back-to-back votes to the same bin count correctly (one vote per cycle max).
- `hits_done` sampled at D: SCAN occupies D+1 … D+RBINS; `peak_vld`=1 at D+RBINS+1 only.
- `busy` falls at D+RBINS+2 if there is no new `start`.
- `hit_dropped` is high in the cycle after the offending input.
- Throughput: one candidate per (accumulation cycles + RBINS + 2) cycles.
- The upstream r-bin stage has 2 cycles of latency, so the issuer of `hits_done` delays it until the last `r_bin_vld` has emerged.

## Test plan
- Reset then idle: all outputs 0. Assert `rst_n`=0 mid-SCAN: outputs 0 immediately and state IDLE.
- Single candidate: `start`, votes to bins 10,10,10,40,40, `hits_done` with the last vote → `peak_vld` exactly 129 cycles after `hits_done`, `peak_bin`=10, `peak_count`=3, `peak_found`=1.
- Tie and threshold: votes 20,5,20,5 → `peak_bin`=5, `peak_count`=2, `peak_found`=0. Empty candidate → `peak_bin`=0, `peak_count`=0, `peak_found`=0.
- Saturation and back-to-back: 40 consecutive votes to bin 127 → `peak_count`=31, `peak_bin`=127.
- Abort: `start`, 3 votes to bin 7, `hits_done`, `start` again 50 cycles later, then 1 vote to bin 2 and `hits_done` → only one `peak_vld`, with `peak_bin`=2, `peak_count`=1. No residue from bin 7.
- Dropped votes: `r_bin_vld` in IDLE, in the `start` cycle and during SCAN → `hit_dropped` pulses once per vote and the histogram is unaffected. With RBINS=100, `r_bin`=120 in ACCUM → dropped.

Source files
------------

// File: rtl/hough_r_accumulator.sv
// Hough r-bin vote accumulator: saturating histogram over one theta slice,
// followed by a linear peak scan and a one-cycle result report.
module hough_r_accumulator #(
    parameter int W_bin_number_a = 7,
    parameter int RBINS          = 128,
    parameter int W_CNT          = 5,
    parameter int MIN_HITS       = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [W_bin_number_a-1:0] r_bin,
    input  logic                      r_bin_vld,
    input  logic                      hits_done,
    output logic                      busy,
    output logic                      hit_dropped,
    output logic                      peak_vld,
    output logic [W_bin_number_a-1:0] peak_bin,
    output logic [W_CNT-1:0]          peak_count,
    output logic                      peak_found
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SCAN,
        REPORT
    } state_t;

    state_t                    state_q, state_d;
    logic [W_CNT-1:0]          cnt_q [RBINS];
    logic [W_CNT-1:0]          cnt_d [RBINS];
    logic [W_bin_number_a-1:0] scan_idx_q, scan_idx_d;
    logic [W_CNT-1:0]          best_cnt_q, best_cnt_d;
    logic [W_bin_number_a-1:0] best_bin_q, best_bin_d;
    logic                      busy_q, busy_d;
    logic                      hit_dropped_q, hit_dropped_d;
    logic                      peak_vld_q, peak_vld_d;
    logic [W_bin_number_a-1:0] peak_bin_q, peak_bin_d;
    logic [W_CNT-1:0]          peak_count_q, peak_count_d;
    logic                      peak_found_q, peak_found_d;

    logic                      vote_ok;
    logic [W_CNT-1:0]          scan_cnt;
    logic                      scan_better;
    logic [W_CNT-1:0]          final_cnt;
    logic [W_bin_number_a-1:0] final_bin;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        scan_idx_d    = scan_idx_q;
        best_cnt_d    = best_cnt_q;
        best_bin_d    = best_bin_q;
        peak_vld_d    = 1'b0;
        peak_bin_d    = peak_bin_q;
        peak_count_d  = peak_count_q;
        peak_found_d  = peak_found_q;

        vote_ok       = r_bin_vld && (state_q == ACCUM) && !start && (32'(r_bin) < RBINS);
        hit_dropped_d = r_bin_vld && !vote_ok;

        scan_cnt      = cnt_q[scan_idx_q];
        scan_better   = scan_cnt > best_cnt_q;
        final_cnt     = scan_better ? scan_cnt : best_cnt_q;
        final_bin     = scan_better ? scan_idx_q : best_bin_q;

        if (start) begin
            for (int unsigned i = 0; i < RBINS; i++) begin
                cnt_d[i] = '0;
            end
            scan_idx_d   = '0;
            best_cnt_d   = '0;
            best_bin_d   = '0;
            peak_bin_d   = '0;
            peak_count_d = '0;
            peak_found_d = 1'b0;
            state_d      = ACCUM;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (vote_ok && (cnt_q[r_bin] != '1)) begin
                        cnt_d[r_bin] = cnt_q[r_bin] + 1'b1;
                    end
                    if (hits_done) begin
                        scan_idx_d = '0;
                        state_d    = SCAN;
                    end
                end
                SCAN: begin
                    best_cnt_d = final_cnt;
                    best_bin_d = final_bin;
                    // The last bin's comparison is folded straight into the
                    // registered result so peak_vld lines up with REPORT.
                    if (32'(scan_idx_q) == RBINS - 1) begin
                        peak_vld_d   = 1'b1;
                        peak_bin_d   = final_bin;
                        peak_count_d = final_cnt;
                        peak_found_d = 32'(final_cnt) >= MIN_HITS;
                        state_d      = REPORT;
                    end else begin
                        scan_idx_d = scan_idx_q + 1'b1;
                    end
                end
                REPORT:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            for (int unsigned i = 0; i < RBINS; i++) begin
                cnt_q[i] <= '0;
            end
            scan_idx_q    <= '0;
            best_cnt_q    <= '0;
            best_bin_q    <= '0;
            busy_q        <= 1'b0;
            hit_dropped_q <= 1'b0;
            peak_vld_q    <= 1'b0;
            peak_bin_q    <= '0;
            peak_count_q  <= '0;
            peak_found_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            scan_idx_q    <= scan_idx_d;
            best_cnt_q    <= best_cnt_d;
            best_bin_q    <= best_bin_d;
            busy_q        <= busy_d;
            hit_dropped_q <= hit_dropped_d;
            peak_vld_q    <= peak_vld_d;
            peak_bin_q    <= peak_bin_d;
            peak_count_q  <= peak_count_d;
            peak_found_q  <= peak_found_d;
        end
    end

    assign busy        = busy_q;
    assign hit_dropped = hit_dropped_q;
    assign peak_vld    = peak_vld_q;
    assign peak_bin    = peak_bin_q;
    assign peak_count  = peak_count_q;
    assign peak_found  = peak_found_q;

endmodule

// File: tb/tb_hough_r_accumulator.sv
// Directed bench for hough_r_accumulator: default 128-bin instance plus a
// 100-bin instance for out-of-range bin rejection.
module tb_hough_r_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, r_bin_vld, hits_done;
    logic [6:0] r_bin;
    logic       busy, hit_dropped, peak_vld, peak_found;
    logic [6:0] peak_bin;
    logic [4:0] peak_count;

    logic       start100, r_bin_vld100, hits_done100;
    logic [6:0] r_bin100;
    logic       busy100, hit_dropped100, peak_vld100, peak_found100;
    logic [6:0] peak_bin100;
    logic [4:0] peak_count100;

    int checks   = 0;
    int failures = 0;
    int n;
    int pulses;

    always #5 clk = ~clk;

    hough_r_accumulator #(
        .W_bin_number_a(7), .RBINS(128), .W_CNT(5), .MIN_HITS(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .r_bin(r_bin),
        .r_bin_vld(r_bin_vld), .hits_done(hits_done), .busy(busy),
        .hit_dropped(hit_dropped), .peak_vld(peak_vld), .peak_bin(peak_bin),
        .peak_count(peak_count), .peak_found(peak_found)
    );

    hough_r_accumulator #(
        .W_bin_number_a(7), .RBINS(100), .W_CNT(5), .MIN_HITS(3)
    ) dut100 (
        .clk(clk), .rst_n(rst_n), .start(start100), .r_bin(r_bin100),
        .r_bin_vld(r_bin_vld100), .hits_done(hits_done100), .busy(busy100),
        .hit_dropped(hit_dropped100), .peak_vld(peak_vld100), .peak_bin(peak_bin100),
        .peak_count(peak_count100), .peak_found(peak_found100)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Ticks until peak_vld, returning the tick count (or -1 after a bound).
    task automatic wait_peak(output int cnt);
        cnt = -1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (peak_vld) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic vote(input logic [6:0] b, input logic last);
        r_bin_vld = 1'b1;
        r_bin     = b;
        hits_done = last;
        tick();
        r_bin_vld = 1'b0;
        hits_done = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 0; r_bin_vld = 0; hits_done = 0; r_bin = '0;
        start100 = 0; r_bin_vld100 = 0; hits_done100 = 0; r_bin100 = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_drop", hit_dropped, 0);
        chk("rst_vld", peak_vld, 0);
        chk("rst_bin", peak_bin, 0);
        chk("rst_cnt", peak_count, 0);
        chk("rst_found", peak_found, 0);

        // single candidate: 10,10,10,40,40
        do_start();
        chk("c1_busy", busy, 1);
        vote(7'd10, 0); vote(7'd10, 0); vote(7'd10, 0); vote(7'd40, 0); vote(7'd40, 1);
        chk("c1_busy_scan", busy, 1);
        wait_peak(n);
        chk("c1_latency", n, 128);
        chk("c1_bin", peak_bin, 10);
        chk("c1_cnt", peak_count, 3);
        chk("c1_found", peak_found, 1);
        chk("c1_busy_rep", busy, 1);
        tick();
        chk("c1_vld_pulse", peak_vld, 0);
        chk("c1_busy_fall", busy, 0);
        chk("c1_bin_hold", peak_bin, 10);

        // tie keeps lowest index, below threshold
        do_start();
        chk("tie_cleared", peak_count, 0);
        vote(7'd20, 0); vote(7'd5, 0); vote(7'd20, 0); vote(7'd5, 1);
        wait_peak(n);
        chk("tie_latency", n, 128);
        chk("tie_bin", peak_bin, 5);
        chk("tie_cnt", peak_count, 2);
        chk("tie_found", peak_found, 0);

        // empty candidate
        do_start();
        hits_done = 1'b1; tick(); hits_done = 1'b0;
        wait_peak(n);
        chk("empty_latency", n, 128);
        chk("empty_bin", peak_bin, 0);
        chk("empty_cnt", peak_count, 0);
        chk("empty_found", peak_found, 0);

        // saturation with back-to-back votes to bin 127
        do_start();
        for (int i = 0; i < 40; i++) vote(7'd127, i == 39);
        wait_peak(n);
        chk("sat_bin", peak_bin, 127);
        chk("sat_cnt", peak_count, 31);
        chk("sat_found", peak_found, 1);

        // abort mid-scan
        do_start();
        vote(7'd7, 0); vote(7'd7, 0); vote(7'd7, 1);
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (peak_vld) pulses++;
        end
        do_start();
        vote(7'd2, 1);
        wait_peak(n);
        chk("abort_no_early_vld", pulses, 0);
        chk("abort_latency", n, 128);
        chk("abort_bin", peak_bin, 2);
        chk("abort_cnt", peak_count, 1);
        pulses = 0;
        for (int i = 0; i < 140; i++) begin
            tick();
            if (peak_vld) pulses++;
        end
        chk("abort_no_extra_vld", pulses, 0);

        // dropped votes: IDLE, start cycle, SCAN
        vote(7'd10, 0);
        chk("drop_idle", hit_dropped, 1);
        tick();
        chk("drop_idle_pulse", hit_dropped, 0);
        start = 1'b1; r_bin_vld = 1'b1; r_bin = 7'd10; tick();
        start = 1'b0; r_bin_vld = 1'b0;
        chk("drop_start", hit_dropped, 1);
        tick();
        chk("drop_accum_quiet", hit_dropped, 0);
        vote(7'd3, 1);
        chk("drop_counted_vote", hit_dropped, 0);
        vote(7'd10, 0);
        chk("drop_scan", hit_dropped, 1);
        wait_peak(n);
        chk("drop_latency", n, 127);
        chk("drop_bin", peak_bin, 3);
        chk("drop_cnt", peak_count, 1);

        // 100-bin instance rejects r_bin 120
        start100 = 1'b1; tick(); start100 = 1'b0;
        r_bin_vld100 = 1'b1; r_bin100 = 7'd120; tick();
        chk("r100_drop", hit_dropped100, 1);
        r_bin100 = 7'd99; tick();
        chk("r100_ok", hit_dropped100, 0);
        hits_done100 = 1'b1; tick();
        r_bin_vld100 = 1'b0; hits_done100 = 1'b0;
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (peak_vld100) begin
                n = i;
                break;
            end
        end
        chk("r100_latency", n, 100);
        chk("r100_bin", peak_bin100, 99);
        chk("r100_cnt", peak_count100, 2);

        // async reset mid-scan
        do_start();
        vote(7'd10, 1);
        for (int i = 0; i < 20; i++) tick();
        chk("mid_scan_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_vld", peak_vld, 0);
        chk("arst_cnt", peak_count, 0);
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (peak_vld || busy) pulses++;
        end
        chk("arst_idle", pulses, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
